fifo_frame_reader: RTL and testbench

- Read-side consumer of the async FWFT data FIFO, in the read clock domain.
- Pops framed words ({sop, eop, data}) from the FIFO whenever downstream can accept them.
- Checks framing (hunt for SOP, max length, stray SOP) and presents a registered valid/ready stream with frame length and error tag on the EOP beat.
- Feeds the downstream frame parser/switch stage.

---
 rtl/fifo_frame_pkg.sv | 23 ++
 rtl/frame_out_reg.sv | 42 ++++
 rtl/fifo_frame_reader.sv | 147 ++++++++++++++
 tb/tb_fifo_frame_reader.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_frame_pkg.sv
// Shared definitions for the framed FIFO word ({sop, eop, data}) used by the
// FIFO writer and by fifo_frame_reader.
package fifo_frame_pkg;

  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  function automatic int sop_bit(input int dw);
    return dw + 1;
  endfunction

  function automatic int eop_bit(input int dw);
    return dw;
  endfunction

  function automatic int word_width(input int dw);
    return dw + 2;
  endfunction

endpackage

// File: rtl/frame_out_reg.sv
// Valid/ready output register for fifo_frame_reader: loads a beat, holds it
// while stalled, and clears once the beat is taken with nothing new behind it.
module frame_out_reg #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] d_data,
  input  logic                  d_sop,
  input  logic                  d_eop,
  input  logic [LEN_WIDTH-1:0]  d_len,
  input  logic                  d_err,
  input  logic                  m_ready,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_sop,
  output logic                  m_eop,
  output logic [LEN_WIDTH-1:0]  m_len,
  output logic                  m_err
);

  always_ff @(posedge clk) begin
    if (!rst_n || (!load && m_valid && m_ready)) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_sop   <= 1'b0;
      m_eop   <= 1'b0;
      m_len   <= '0;
      m_err   <= 1'b0;
    end else if (load) begin
      m_valid <= 1'b1;
      m_data  <= d_data;
      m_sop   <= d_sop;
      m_eop   <= d_eop;
      m_len   <= d_len;
      m_err   <= d_err;
    end
  end

endmodule

// File: rtl/fifo_frame_reader.sv
// Read-side framer for the FWFT data FIFO: pops words, enforces SOP/EOP framing
// and max length, and drives a registered valid/ready stream.
// Optional counters: define FIFO_FRAME_READER_STAT_EN.
module fifo_frame_reader
  import fifo_frame_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int MAX_FRAME_LEN = 1536,
  parameter int LEN_WIDTH     = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH+1:0] fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_sop,
  output logic                  m_eop,
  output logic [LEN_WIDTH-1:0]  m_len,
  output logic                  m_err,
  output logic                  err_sop,
  output logic                  err_trunc
`ifdef FIFO_FRAME_READER_STAT_EN
  ,
  input  logic                  stat_clr,
  output logic [31:0]           stat_frames,
  output logic [15:0]           stat_errs
`endif
);

  localparam int SOP = sop_bit(DATA_WIDTH);
  localparam int EOP = eop_bit(DATA_WIDTH);
  localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_FRAME_LEN);
  localparam logic [LEN_WIDTH-1:0] ONE     = LEN_WIDTH'(1);

  state_t               state, state_nxt;
  logic [LEN_WIDTH-1:0] len_cnt, len_nxt, len_inc;
  logic                 w_sop, w_eop;
  logic                 emit, b_sop, b_eop, b_err;
  logic [LEN_WIDTH-1:0] b_len;
  logic                 sop_hit, trunc_hit;

  assign fifo_rd_en = rst_n & ~fifo_empty & (~m_valid | m_ready);
  assign w_sop      = fifo_dout[SOP];
  assign w_eop      = fifo_dout[EOP];
  assign len_inc    = len_cnt + ONE;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_HUNT;
      len_cnt   <= '0;
      err_sop   <= 1'b0;
      err_trunc <= 1'b0;
    end else begin
      state     <= state_nxt;
      len_cnt   <= len_nxt;
      err_sop   <= sop_hit;
      err_trunc <= trunc_hit;
    end
  end

  always_comb begin
    state_nxt = state;
    len_nxt   = len_cnt;
    emit      = 1'b0;
    b_sop     = 1'b0;
    b_eop     = 1'b0;
    b_len     = '0;
    b_err     = 1'b0;
    sop_hit   = 1'b0;
    trunc_hit = 1'b0;
    if (fifo_rd_en) begin
      // A SOP restarts the frame everywhere except a SOP+EOP word while dropping,
      // which just closes the dropped frame.
      if (w_sop && !(state == ST_DROP && w_eop)) begin
        emit      = 1'b1;
        b_sop     = 1'b1;
        sop_hit   = (state == ST_PASS);
        b_eop     = w_eop;
        b_len     = w_eop ? ONE : '0;
        len_nxt   = w_eop ? '0 : ONE;
        state_nxt = w_eop ? ST_HUNT : ST_PASS;
      end else begin
        unique case (state)
          ST_PASS: begin
            emit = 1'b1;
            if (w_eop) begin
              b_eop     = 1'b1;
              b_len     = len_inc;
              len_nxt   = '0;
              state_nxt = ST_HUNT;
            end else if (len_inc == MAX_LEN) begin
              b_eop     = 1'b1;
              b_err     = 1'b1;
              b_len     = MAX_LEN;
              trunc_hit = 1'b1;
              len_nxt   = '0;
              state_nxt = ST_DROP;
            end else begin
              len_nxt = len_inc;
            end
          end
          ST_DROP: if (w_eop) state_nxt = ST_HUNT;
          default: ;
        endcase
      end
    end
  end

  frame_out_reg #(
    .DATA_WIDTH(DATA_WIDTH),
    .LEN_WIDTH (LEN_WIDTH)
  ) u_out (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (emit),
    .d_data (fifo_dout[DATA_WIDTH-1:0]),
    .d_sop  (b_sop),
    .d_eop  (b_eop),
    .d_len  (b_len),
    .d_err  (b_err),
    .m_ready(m_ready),
    .m_valid(m_valid),
    .m_data (m_data),
    .m_sop  (m_sop),
    .m_eop  (m_eop),
    .m_len  (m_len),
    .m_err  (m_err)
  );

`ifdef FIFO_FRAME_READER_STAT_EN
  always_ff @(posedge clk) begin
    if (!rst_n || stat_clr) begin
      stat_frames <= '0;
      stat_errs   <= '0;
    end else begin
      if (m_valid && m_ready && m_eop && stat_frames != '1)
        stat_frames <= stat_frames + 32'd1;
      if ((err_sop || err_trunc) && stat_errs != '1)
        stat_errs <= stat_errs + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Randomized bench for fifo_frame_reader against a frame-level reference model.
module tb_fifo_frame_reader;
  localparam int DW = 8, MAXL = 8, LW = 4;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [DW+1:0] fifo_dout = '0;
  logic          fifo_empty = 1'b1, fifo_rd_en;
  logic          m_valid, m_ready = 1'b0, m_sop, m_eop, m_err, err_sop, err_trunc;
  logic [DW-1:0] m_data;
  logic [LW-1:0] m_len;

  always #5 clk = ~clk;

  fifo_frame_reader #(.DATA_WIDTH(DW), .MAX_FRAME_LEN(MAXL), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_sop(m_sop), .m_eop(m_eop), .m_len(m_len), .m_err(m_err),
    .err_sop(err_sop), .err_trunc(err_trunc));

  logic [DW+1:0] q[$];
  logic [15:0]   exp_q[$];
  int n_cmp = 0, n_bad = 0, cyc = 0, tog = 0;
  int rdy_mode = 0, bub_pct = 0;
  int exp_sop_err = 0, exp_trunc = 0, got_sop_err = 0, got_trunc = 0;
  int mst = 0, mlen = 0;  // model: 0 idle, 1 in frame, 2 dropping rest of frame
  int first_pop = -1, first_acc = -1, last_acc = -1;
  bit stall_prev = 1'b0;
  logic [15:0] stall_val = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pk(input bit s, input bit e, input bit er,
                                     input logic [LW-1:0] l, input logic [DW-1:0] d);
    return {1'b0, er, l, s, e, d};
  endfunction

  // Queue a FIFO word and derive its expected effect from the framing rules.
  task automatic push(input bit s, input bit e, input logic [DW-1:0] d);
    q.push_back({s, e, d});
    if (s && !(mst == 2 && e)) begin
      if (mst == 1) exp_sop_err++;
      mlen = 1;
      exp_q.push_back(pk(1'b1, e, 1'b0, e ? LW'(1) : LW'(0), d));
      mst = e ? 0 : 1;
    end else if (mst == 1) begin
      mlen++;
      if (e) begin
        exp_q.push_back(pk(1'b0, 1'b1, 1'b0, LW'(mlen), d));
        mst = 0;
      end else if (mlen == MAXL) begin
        exp_q.push_back(pk(1'b0, 1'b1, 1'b1, LW'(MAXL), d));
        exp_trunc++;
        mst = 2;
      end else begin
        exp_q.push_back(pk(1'b0, 1'b0, 1'b0, LW'(0), d));
      end
    end else if (mst == 2 && e) begin
      mst = 0;
    end
  endtask

  task automatic push_frame(input int n, input bit with_eop);
    for (int i = 0; i < n; i++)
      push(i == 0, with_eop && (i == n - 1), DW'($urandom));
  endtask

  task automatic step();
    logic [15:0] cur;
    bit pop, acc;
    @(negedge clk);
    fifo_empty = (q.size() == 0) || ($urandom_range(99) < bub_pct);
    fifo_dout  = (q.size() != 0) ? q[0] : (DW+2)'($urandom);
    case (rdy_mode)
      0: m_ready = 1'b1;
      1: m_ready = 1'($urandom_range(1));
      2: m_ready = (tog % 3 == 0);
      default: m_ready = 1'b0;
    endcase
    tog++;
    #1;
    cur = pk(m_sop, m_eop, m_err, m_len, m_data);
    chk("rd_en", fifo_rd_en, rst_n & ~fifo_empty & (~m_valid | m_ready));
    if (stall_prev) begin
      chk("stall_vld", m_valid, 1);
      chk("stall_hold", cur, stall_val);
    end
    got_sop_err += int'(err_sop);
    got_trunc   += int'(err_trunc);
    pop = fifo_rd_en;
    acc = m_valid & m_ready;
    stall_prev = m_valid & ~m_ready;
    stall_val  = cur;
    @(posedge clk);
    cyc++;
    if (pop) begin
      void'(q.pop_front());
      if (first_pop < 0) first_pop = cyc;
    end
    if (acc) begin
      if (exp_q.size() == 0) chk("extra_beat", cur, 0);
      else chk("beat", cur, exp_q.pop_front());
      if (first_acc < 0) first_acc = cyc;
      last_acc = cyc;
    end
    #1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((q.size() != 0 || m_valid) && n < 5000) begin
      step();
      n++;
    end
    if (n >= 5000) chk({tag, "_timeout"}, 1, 0);
    step();
    step();
    chk({tag, "_left"}, exp_q.size(), 0);
    chk({tag, "_err_sop"}, got_sop_err, exp_sop_err);
    chk({tag, "_err_trunc"}, got_trunc, exp_trunc);
  endtask

  // Reset drops the pending beat and partial frame; unpopped words are
  // re-evaluated from the idle state.
  task automatic do_reset();
    logic [DW+1:0] tmp[$];
    @(negedge clk);
    rst_n = 1'b0;
    m_ready = 1'b0;
    fifo_empty = (q.size() == 0);
    fifo_dout  = (q.size() != 0) ? q[0] : '0;
    #1;
    chk("rst_rd_en", fifo_rd_en, 0);
    @(posedge clk);
    #1;
    chk("rst_out", {m_valid, m_sop, m_eop, m_err, err_sop, err_trunc, m_len, m_data}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    stall_prev = 1'b0;
    tmp = q;
    q.delete();
    exp_q.delete();
    mst = 0;
    foreach (tmp[i]) push(tmp[i][DW+1], tmp[i][DW], tmp[i][DW-1:0]);
  endtask

  initial begin
    do_reset();

    // 4-word frame, always ready: 1-cycle latency, back-to-back beats
    rdy_mode = 0; bub_pct = 0;
    first_pop = -1; first_acc = -1; last_acc = -1;
    push_frame(4, 1'b1);
    drain("t1");
    chk("t1_latency", first_acc - first_pop, 1);
    chk("t1_burst", last_acc - first_acc, 3);

    // garbage then single-word frame
    for (int i = 0; i < 3; i++) push(1'b0, 1'($urandom_range(1)), DW'($urandom));
    push(1'b1, 1'b1, 8'hA5);
    drain("t2");

    // over-length frame then a normal one
    push_frame(12, 1'b1);
    push_frame(3, 1'b1);
    drain("t3");

    // frame without EOP interrupted by a new SOP frame
    push_frame(3, 1'b0);
    push_frame(2, 1'b1);
    drain("t4");

    // back-pressure pattern 1,0,0
    rdy_mode = 2;
    push_frame(7, 1'b1);
    drain("t5");

    // reset mid-frame with a stalled beat pending
    rdy_mode = 0;
    push_frame(5, 1'b0);
    for (int i = 0; i < 8 && q.size() != 0; i++) step();
    rdy_mode = 3;
    push(1'b0, 1'b0, 8'h11);
    push(1'b0, 1'b0, 8'h22);
    step(); step(); step();
    do_reset();
    push(1'b0, 1'b0, 8'h33);
    push(1'b0, 1'b1, 8'h44);
    rdy_mode = 1;
    push_frame(3, 1'b1);
    drain("t6");

    // random word stream with bubbles and random back-pressure
    rdy_mode = 1; bub_pct = 25;
    for (int i = 0; i < 600; i++)
      push($urandom_range(99) < 15, $urandom_range(99) < 20, DW'($urandom));
    drain("t7");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
